mips_cpu_muldiv: RTL



---
 rtl/mips_cpu_muldiv.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_muldiv
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit (one bit per cycle) with
//            architectural HI/LO registers and single-cycle MTHI/MTLO.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dbz;

    logic                 w_signed;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_signed = (op == 3'd0) || (op == 3'd2);
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: r_acc = {partial product, remaining multiplier bits}
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    // Divide: r_acc = {remainder, remaining dividend / quotient bits}
    assign w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd4: hi <= a;
                            3'd5: lo <= a;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                busy     <= 1'b1;
                                r_count  <= '0;
                                r_is_div <= op[1];
                                r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                                r_neg_r  <= w_signed && a[WIDTH-1];
                                r_dbz    <= op[1] && (b == '0);
                                if (op[1]) begin
                                    r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                                    r_opnd  <= w_abs_b;
                                    r_state <= (b == '0) ? S_FIX : S_RUN;
                                end else begin
                                    r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                                    r_opnd  <= w_abs_a;
                                    r_state <= S_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_count <= r_count + c_CNT_W'(1);
                    if (r_is_div) begin
                        // Restoring step: keep the subtraction only if it did not borrow
                        if (!w_trial[WIDTH])
                            r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                        else
                            r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    end
                    if (r_count == c_LAST)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= r_dbz;
                    if (!r_dbz) begin
                        if (r_is_div) begin
                            hi <= w_rem;
                            lo <= w_quo;
                        end else begin
                            {hi, lo} <= w_prod;
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
